// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer: FSM state
// encoding, PC step, and RISC-V immediate field positions with extract helpers.
package fetch_seq_pkg;

    localparam int              XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    localparam int IMM_SIGN = 31;

    localparam int J_HI_MSB = 19;
    localparam int J_HI_LSB = 12;
    localparam int J_B11    = 20;
    localparam int J_LO_MSB = 30;
    localparam int J_LO_LSB = 21;

    localparam int B_B11    = 7;
    localparam int B_HI_MSB = 30;
    localparam int B_HI_LSB = 25;
    localparam int B_LO_MSB = 11;
    localparam int B_LO_LSB = 8;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    function automatic logic [XLEN-1:0] j_imm(input logic [XLEN-1:0] w);
        j_imm = {{12{w[IMM_SIGN]}}, w[J_HI_MSB:J_HI_LSB], w[J_B11],
                 w[J_LO_MSB:J_LO_LSB], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] b_imm(input logic [XLEN-1:0] w);
        b_imm = {{20{w[IMM_SIGN]}}, w[B_B11], w[B_HI_MSB:B_HI_LSB],
                 w[B_LO_MSB:B_LO_LSB], 1'b0};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: JALR > JAL > branch > sequential.
// FETCH_SEQ_MISALIGN_TRAP_EN: report misaligned targets instead of clearing bits[1:0].
module next_pc_calc
    import fetch_seq_pkg::*;
(
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_instr_addr,
    input  logic            i_should_branch,
    input  logic            i_should_jump,
    input  logic            i_use_reg_target,
    input  logic [XLEN-1:0] i_reg_target,
    output logic [XLEN-1:0] o_target,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_sel;
    logic            w_is_jalr;
    logic            w_unused;

    assign w_is_jalr = i_should_jump & i_use_reg_target;

    always_comb begin
        w_raw = i_instr_addr + PC_STEP;
        if (w_is_jalr) begin
            w_raw = i_reg_target;
        end else if (i_should_jump) begin
            w_raw = i_instr_addr + j_imm(i_instr);
        end else if (i_should_branch) begin
            w_raw = i_instr_addr + b_imm(i_instr);
        end
    end

    // JALR clears bit 0, but alignment is judged on the target execute handed us.
    assign w_sel = w_is_jalr ? {w_raw[XLEN-1:1], 1'b0} : w_raw;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    assign o_target     = w_sel;
    assign o_misaligned = (w_raw[1:0] != 2'b00);
    assign w_unused     = ^i_instr[6:0];
`else
    assign o_target     = {w_sel[XLEN-1:2], 2'b00};
    assign o_misaligned = 1'b0;
    assign w_unused     = ^{i_instr[6:0], w_sel[1:0]};
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller owning the PC: request, wait, hold for execute, redirect.
// FETCH_SEQ_MISALIGN_TRAP_EN enables the sticky misaligned-target FAULT state.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_addr,
    input  logic            should_branch,
    input  logic            should_jump,
    input  logic            use_reg_target,
    input  logic [XLEN-1:0] reg_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] retire_count,
    output logic            fault,
    output logic [2:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid is decoded from state only and, once raised, holds (with stable payload)
    // until that transfer. imem_resp_valid is a one-cycle pulse honoured only in WAIT.

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_addr;
    logic [XLEN-1:0] r_retire;
    logic            r_fault;

    logic            w_req_valid;
    logic            w_instr_valid;
    logic            w_resp_take;
    logic            w_retire;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;

    next_pc_calc u_next_pc (
        .i_instr          (r_instr),
        .i_instr_addr     (r_instr_addr),
        .i_should_branch  (should_branch),
        .i_should_jump    (should_jump),
        .i_use_reg_target (use_reg_target),
        .i_reg_target     (reg_target),
        .o_target         (w_target),
        .o_misaligned     (w_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_valid   = 1'b0;
        w_instr_valid = 1'b0;
        w_resp_take   = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    w_resp_take = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_instr_valid = 1'b1;
                if (instr_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = w_misaligned ? ST_FAULT : ST_REQ;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_instr_addr <= '0;
            r_retire     <= '0;
            r_fault      <= 1'b0;
        end else begin
            if (w_resp_take) begin
                r_instr      <= imem_resp_data;
                r_instr_addr <= r_pc;
            end
            if (w_retire) begin
                r_pc     <= w_target;
                r_retire <= r_retire + 32'd1;
                if (w_misaligned) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = w_instr_valid;
    assign instr          = r_instr;
    assign instr_addr     = r_instr_addr;
    assign pc             = r_pc;
    assign retire_count   = r_retire;
    assign fault          = r_fault;
    assign dbg_state      = r_state;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller that owns the program counter. It issues one request at a time to instruction memory and holds the returned word for the execute stage. After execute accepts that word, it selects the next PC: sequential, conditional branch (B-immediate), JAL (J-immediate) or register-indirect (JALR). It sits between instruction memory and decode/execute and replaces the fixed `pc + 4` next-PC path.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `imem_req_valid` out 1, fetch request
- `imem_req_ready` in 1, memory accepts request
- `imem_req_addr` out 32, fetch address (= `pc`)
- `imem_resp_valid` in 1, read data valid (one-cycle pulse)
- `imem_resp_data` in 32, instruction word
- `instr_valid` out 1, held instruction available to execute
- `instr_ready` in 1, execute consumes instruction and resolves control flow this cycle
- `instr` out 32, held instruction word
- `instr_addr` out 32, address of held instruction
- `should_branch` in 1, taken conditional branch; sampled on `instr_valid & instr_ready`
- `should_jump` in 1, unconditional jump; sampled likewise
- `use_reg_target` in 1, with `should_jump`: target is `reg_target` (JALR)
- `reg_target` in 32, rs1+imm computed by execute
- `pc` out 32, current PC register
- `retire_count` out 32, instructions consumed since reset
- `fault` out 1, sticky misaligned-target flag

## Operation
- States: BOOT, REQ, WAIT, HOLD, FAULT. Reset state is BOOT.
- BOOT -> REQ unconditionally.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready` -> WAIT. `imem_resp_valid` is ignored in REQ.
- WAIT: on `imem_resp_valid`, register `imem_resp_data` into `instr` and `pc` into `instr_addr`, then -> HOLD.
- HOLD: `instr_valid`=1 and `instr`/`instr_addr` stay stable until `instr_ready`. On handshake:
  - `pc` <= `target`
  - `retire_count` += 1 (wraps at 2^32)
  - -> REQ
- Target priority:
  - `should_jump & use_reg_target`: `reg_target & ~1`
  - else `should_jump`: `instr_addr + J-imm`, where J-imm = {12×instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - else `should_branch`: `instr_addr + B-imm`, where B-imm = {20×instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - else: `instr_addr + 4`
- `should_jump` and `should_branch` both set: jump wins.
- All adds are 32-bit and wrap modulo 2^32, no carry out.
- Reset values:
  - `pc` = `RESET_PC`
  - `instr`, `instr_addr`, `retire_count` = 0
  - `imem_req_valid`, `instr_valid`, `fault` = 0
- `rst_n` asserted in any state returns to BOOT immediately. Instruction memory shares `rst_n`, so no stale response is delivered after reset.
- FAULT: all valid outputs 0, handshake inputs ignored, leaves only on reset.

## Timing
- All outputs are registered or decoded from state only; no combinational input-to-output paths.
- Request accepted at cycle N, response at N+k (k>=1): `instr_valid`=1 from N+k+1.
- Handshake at cycle M: `imem_req_valid`=1 with the new `pc` from M+1.
- Zero-wait memory and execute give a minimum of 3 cycles per instruction (REQ, WAIT, HOLD).
- First `imem_req_valid` appears 2 cycles after `rst_n` deassertion (BOOT, then REQ).
- `imem_req_addr` is stable while `imem_req_valid` & !`imem_req_ready`.

## Configuration
- `FETCH_SEQ_MISALIGN_TRAP_EN` defined:
  - a selected target with bits[1:0] != 0 on handshake loads `pc`, goes to FAULT and sets `fault`=1
  - `retire_count` still increments for that instruction
- Undefined:
  - target bits[1:0] are forced to 0, the sequencer never enters FAULT
  - `fault` is tied 0

## Structure
- Package `fetch_seq_pkg` holds:
  - state enum (BOOT, REQ, WAIT, HOLD, FAULT)
  - `PC_STEP` = 4
  - `XLEN` = 32
  - immediate field bit-position constants
- Sub-module `next_pc_calc` (combinational): immediate extraction, target priority select, alignment handling. The FSM and registers stay in `fetch_sequencer`.

## Test plan
- Reset with `RESET_PC`=32'h100, memory ready always, 1-cycle response, execute always ready:
  - request addresses are 0x100, 0x104, 0x108
  - `retire_count` = 3 after the third handshake
- Held word 32'hFE000EE3 (BEQ, -4) at 0x200 with `should_branch`=1 -> next `imem_req_addr` = 0x1FC.
- Held word 32'h0080006F (JAL +8) at 0x300 with `should_jump`=1 and `should_branch`=1 -> next `imem_req_addr` = 0x308 (jump wins).
- `use_reg_target`=1, `reg_target`=32'h0000_0405, `should_jump`=1:
  - with `FETCH_SEQ_MISALIGN_TRAP_EN`: `fault`=1 and no further `imem_req_valid`
  - without: next address is 0x404
- Back-pressure:
  - `imem_req_ready` low for 5 cycles: address held constant, exactly one request accepted
  - `instr_ready` low for 4 cycles: `instr` stable, no new request issued
- `rst_n` pulsed low while in WAIT:
  - all outputs return to reset values in the same cycle
  - first request after release is at `RESET_PC`
  - `retire_count` = 0
